// File: rtl/mealy_ser_pkg.sv
// Shared types and sizing helpers for the Mealy bit serializer.
// MEALY_SER_PARITY_EN adds one even-parity bit to each frame.
package mealy_ser_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

`ifdef MEALY_SER_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  // Bit-counter width able to hold 0..frame_len-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    if (frame_len <= 2) begin
      return 1;
    end
    return $clog2(frame_len);
  endfunction

endpackage

// File: rtl/mealy_ser_buf.sv
// One-entry holding register for the word queued behind the frame in flight.
module mealy_ser_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  // A write while full is dropped so a stalled word is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (wr_en && !full_q) begin
      full_q <= 1'b1;
      data_q <= wr_data;
    end else if (rd_en) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/mealy_bit_serializer.sv
// Parallel-to-serial framer feeding a Mealy detector; hold gates the outputs combinationally.
// MEALY_SER_PARITY_EN appends an even-parity bit after the data bits.
module mealy_bit_serializer
  import mealy_ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned FrameLen = WIDTH + ParityBits;
  localparam int unsigned CntW     = cnt_width(FrameLen);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;
  logic             x_bit_q;
`ifdef MEALY_SER_PARITY_EN
  localparam logic [CntW-1:0] LastDataCnt = CntW'(WIDTH - 1);
  logic             parity_q;
`endif

  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic             buf_wr;
  logic             buf_rd;

  logic             in_shift;
  logic             advance;
  logic             frame_end;
  logic             accept;
  logic             start_direct;
  logic             reload;
  logic [WIDTH-1:0] new_word;
  logic [WIDTH-1:0] sr_shift;
  logic             next_bit;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  assign in_shift  = (state_q == StShift);
  assign advance   = in_shift && !hold;
  assign frame_end = advance && (cnt_q == LastCnt);

  // Ready reflects BUF occupancy at the start of the cycle only.
  assign accept = load_valid && !buf_full;

  // With BUF empty at the last bit, a fresh word bypasses BUF and starts at once.
  assign start_direct = accept && (!in_shift || frame_end);
  assign buf_wr       = accept && in_shift && !frame_end;
  assign buf_rd       = frame_end && buf_full;
  assign reload       = start_direct || buf_rd;
  assign new_word     = buf_rd ? buf_data : load_data;

  always_comb begin
    if (LSB_FIRST) begin
      sr_shift = {1'b0, sr_q[WIDTH-1:1]};
    end else begin
      sr_shift = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    next_bit = first_bit(sr_shift);
`ifdef MEALY_SER_PARITY_EN
    if (cnt_q == LastDataCnt) begin
      next_bit = parity_q;
    end
`endif
  end

  mealy_ser_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (buf_wr),
    .wr_data(load_data),
    .rd_en  (buf_rd),
    .full   (buf_full),
    .data   (buf_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      cnt_q    <= '0;
      x_bit_q  <= 1'b0;
`ifdef MEALY_SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (reload) begin
      state_q  <= StShift;
      sr_q     <= new_word;
      cnt_q    <= '0;
      x_bit_q  <= first_bit(new_word);
`ifdef MEALY_SER_PARITY_EN
      parity_q <= ^new_word;
`endif
    end else if (frame_end) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      x_bit_q <= 1'b0;
    end else if (advance) begin
      sr_q    <= sr_shift;
      cnt_q   <= cnt_q + CntW'(1);
      x_bit_q <= next_bit;
    end
  end

  assign load_ready  = !buf_full;
  assign x_out       = x_bit_q;
  assign x_valid     = advance;
  assign frame_start = advance && (cnt_q == '0);
  assign frame_done  = frame_end;
  assign busy        = in_shift;

endmodule

// File: tb/tb_mealy_bit_serializer.sv
// Scoreboard bench: LSB-first and MSB-first serializers share stimulus, checked against a bit queue.
// Define MEALY_SER_PARITY_EN for both RTL and bench to cover the parity build.
module tb_mealy_bit_serializer;

  localparam int unsigned W = 8;
`ifdef MEALY_SER_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] load_data = '0;

  logic l_ready, l_xo, l_xv, l_fs, l_fd, l_busy;
  logic m_ready, m_xo, m_xv, m_fs, m_fd, m_busy;

  always #5 clk = ~clk;

  mealy_bit_serializer #(
    .WIDTH(W),
    .LSB_FIRST(1'b1)
  ) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (l_ready),
    .hold       (hold),
    .x_out      (l_xo),
    .x_valid    (l_xv),
    .frame_start(l_fs),
    .frame_done (l_fd),
    .busy       (l_busy)
  );

  mealy_bit_serializer #(
    .WIDTH(W),
    .LSB_FIRST(1'b0)
  ) u_msb (
    .clk        (clk),
    .rst        (rst),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (m_ready),
    .hold       (hold),
    .x_out      (m_xo),
    .x_valid    (m_xv),
    .frame_start(m_fs),
    .frame_done (m_fd),
    .busy       (m_busy)
  );

  // One entry per serial bit still owed: LSB-first bit, MSB-first bit, start and done marks.
  typedef struct packed {
    logic bl;
    logic bm;
    logic st;
    logic dn;
  } exp_t;

  exp_t        q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          armed = 1'b0;
  bit          acc_flag = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    exp_t e;
    logic p;
    p = ^w;
    for (int i = 0; i < int'(FL); i++) begin
      if (i < int'(W)) begin
        e.bl = w[i];
        e.bm = w[int'(W) - 1 - i];
      end else begin
        e.bl = p;
        e.bm = p;
      end
      e.st = (i == 0);
      e.dn = (i == int'(FL) - 1);
      q.push_back(e);
    end
  endtask

  // Monitor: a frame is owed until its last bit is shown; BUF is free while under two are owed.
  always @(negedge clk) begin
    int   pend;
    logic busy_e, xv_e, rdy_e;
    exp_t f;
    if (armed) begin
      pend = 0;
      foreach (q[k]) if (q[k].dn) pend++;
      busy_e = (q.size() != 0);
      xv_e   = busy_e && !hold;
      rdy_e  = (pend < 2);
      f      = busy_e ? q[0] : '0;

      chk("lsb_busy", l_busy, busy_e);
      chk("lsb_x_valid", l_xv, xv_e);
      chk("lsb_load_ready", l_ready, rdy_e);
      chk("lsb_x_out", l_xo, f.bl);
      chk("lsb_frame_start", l_fs, xv_e && f.st);
      chk("lsb_frame_done", l_fd, xv_e && f.dn);
      chk("msb_busy", m_busy, busy_e);
      chk("msb_x_valid", m_xv, xv_e);
      chk("msb_load_ready", m_ready, rdy_e);
      chk("msb_x_out", m_xo, f.bm);
      chk("msb_frame_start", m_fs, xv_e && f.st);
      chk("msb_frame_done", m_fd, xv_e && f.dn);

      acc_flag = 1'b0;
      if (xv_e) void'(q.pop_front());
      if (rst) begin
        q.delete();
      end else if (load_valid && rdy_e) begin
        push_frame(load_data);
        acc_flag = 1'b1;
      end
    end
  end

  task automatic cyc(input logic lv, input logic [W-1:0] d, input logic h, input logic r);
    load_valid = lv;
    load_data  = d;
    hold       = h;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    do begin
      cyc(1'b1, w, 1'b0, 1'b0);
      n++;
    end while (!acc_flag && n < 64);
    if (!acc_flag) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout at %0t: got no accept expected accept of %h", $time, w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    send(8'hB4);
    idle(12);

    send(8'h81);
    send(8'h0F);
    idle(22);

    // Hold right after the third bit has been shown.
    send(8'hFF);
    idle(3);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(12);

    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(30);

    // Reset mid-frame with the next word already buffered.
    send(8'hAA);
    send(8'h55);
    idle(3);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(12);

    send(8'h07);
    idle(12);

    repeat (1500) begin
      cyc(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 99) == 0));
    end
    idle(3 * FL);

    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain at %0t: got %0d bits pending expected 0", $time, q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
